// File: rtl/cordic_fft_pkg.sv
// Shared constants and types for the CORDIC-based FFT twiddle rotators.
package cordic_fft_pkg;

    // atan(2^-i) in Q16.16 radians, i = 0..15
    localparam logic signed [31:0] ATAN_TABLE [0:15] = '{
        32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150,
        32'sd4091,  32'sd2047,  32'sd1024,  32'sd512,
        32'sd256,   32'sd128,   32'sd64,    32'sd32,
        32'sd16,    32'sd8,     32'sd4,     32'sd2
    };

    // 1/1.6468 in Q1.15: undoes the CORDIC rotation gain
    localparam int CORDIC_K    = 19898;
    // pi/2 in Q16.16 radians
    localparam int HALF_PI_Q16 = 102944;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_ITER,
        ST_SCALE,
        ST_OUT
    } state_t;

endpackage

// File: rtl/cordic_iter_stage.sv
// One combinational CORDIC micro-rotation in rotation mode: steers (x,y)
// toward the residual angle z by +/-atan(2^-idx).
module cordic_iter_stage
    import cordic_fft_pkg::*;
#(
    parameter int XY_W = 20,
    parameter int Z_W  = 32
) (
    input  logic signed [XY_W-1:0] x_in,
    input  logic signed [XY_W-1:0] y_in,
    input  logic signed [Z_W-1:0]  z_in,
    input  logic [3:0]             idx,
    output logic signed [XY_W-1:0] x_out,
    output logic signed [XY_W-1:0] y_out,
    output logic signed [Z_W-1:0]  z_out
);
    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  atan_val;

    // rotate toward zero residual; the sign of z picks the direction
    always_comb begin
        x_sh     = x_in >>> idx;
        y_sh     = y_in >>> idx;
        atan_val = Z_W'(ATAN_TABLE[idx]);
        if (!z_in[Z_W-1]) begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_val;
        end else begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_val;
        end
    end

endmodule

// File: rtl/fft_stage_5_twiddle_rotator.sv
// Stage-5 twiddle multiplier: fetches -2*pi*k/32 from the external angle ROM,
// rotates (x,y) with an iterative CORDIC, removes the CORDIC gain and hands
// the result downstream over valid/ready.
module fft_stage_5_twiddle_rotator
    import cordic_fft_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 32,
    parameter int ADDR_W  = 4,
    parameter int ITER    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [DATA_W-1:0]  i_x,
    input  logic signed [DATA_W-1:0]  i_y,
    input  logic [ADDR_W-1:0]         i_k,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic signed [ANGLE_W-1:0] i_rom_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [DATA_W-1:0]  o_x,
    output logic signed [DATA_W-1:0]  o_y
);
    // four guard bits hold the 1.647 gain and the negation of the most negative input
    localparam int XY_W   = DATA_W + 4;
    localparam int CNT_W  = 5;
    localparam int PROD_W = XY_W + 17;

    localparam logic signed [ANGLE_W-1:0] HALF_PI    = ANGLE_W'(HALF_PI_Q16);
    localparam logic signed [PROD_W-1:0]  K_GAIN     = PROD_W'(CORDIC_K);
    localparam logic signed [PROD_W-1:0]  ROUND_HALF = PROD_W'(1 << 14);
    localparam logic signed [PROD_W-1:0]  SAT_MAX    = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0]  SAT_MIN    = -SAT_MAX - PROD_W'(1);

    state_t                    state_reg, state_next;
    logic signed [XY_W-1:0]    x_reg, y_reg;
    logic signed [ANGLE_W-1:0] z_reg;
    logic [CNT_W-1:0]          iter_cnt_reg;
    logic [ADDR_W-1:0]         rom_addr_reg;
    logic                      o_ready_reg;
    logic                      o_valid_reg;
    logic signed [DATA_W-1:0]  o_x_reg, o_y_reg;

    logic signed [XY_W-1:0]    x_rot, y_rot;
    logic signed [ANGLE_W-1:0] z_rot;
    logic                      iter_last;

    assign iter_last = (iter_cnt_reg == CNT_W'(ITER - 1));

    cordic_iter_stage #(
        .XY_W (XY_W),
        .Z_W  (ANGLE_W)
    ) u_iter (
        .x_in  (x_reg),
        .y_in  (y_reg),
        .z_in  (z_reg),
        .idx   (iter_cnt_reg[3:0]),
        .x_out (x_rot),
        .y_out (y_rot),
        .z_out (z_rot)
    );

    // gain compensation, round-half-up and saturation, one lane each for x and y
    logic signed [XY_W-1:0]   lane_in  [2];
    logic signed [DATA_W-1:0] lane_out [2];

    assign lane_in[0] = x_reg;
    assign lane_in[1] = y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_scale
            logic signed [PROD_W-1:0] prod;
            logic signed [PROD_W-1:0] shifted;
            assign prod    = PROD_W'(lane_in[gi]) * K_GAIN + ROUND_HALF;
            assign shifted = prod >>> 15;
            assign lane_out[gi] = (shifted > SAT_MAX) ? DATA_W'(SAT_MAX) :
                                  (shifted < SAT_MIN) ? DATA_W'(SAT_MIN) :
                                  shifted[DATA_W-1:0];
        end
    endgenerate

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state sequencing: fixed walk through the pipeline, only OUT waits
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_valid) state_next = ST_ADDR;
            ST_ADDR:  state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_ITER;
            ST_ITER:  if (iter_last) state_next = ST_SCALE;
            ST_SCALE: state_next = ST_OUT;
            ST_OUT:   if (i_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // datapath: capture, pre-rotation, micro-rotations, scaling and output hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            z_reg        <= '0;
            iter_cnt_reg <= '0;
            rom_addr_reg <= '0;
            o_ready_reg  <= 1'b0;
            o_valid_reg  <= 1'b0;
            o_x_reg      <= '0;
            o_y_reg      <= '0;
        end else begin
            o_ready_reg <= (state_next == ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        x_reg        <= {{(XY_W - DATA_W){i_x[DATA_W-1]}}, i_x};
                        y_reg        <= {{(XY_W - DATA_W){i_y[DATA_W-1]}}, i_y};
                        rom_addr_reg <= i_k;
                    end
                end
                ST_LOAD: begin
                    // angles below -pi/2 get a -90 degree head start to stay in CORDIC range
                    if (i_rom_data < -HALF_PI) begin
                        x_reg <= y_reg;
                        y_reg <= -x_reg;
                        z_reg <= i_rom_data + HALF_PI;
                    end else begin
                        z_reg <= i_rom_data;
                    end
                    iter_cnt_reg <= '0;
                end
                ST_ITER: begin
                    x_reg        <= x_rot;
                    y_reg        <= y_rot;
                    z_reg        <= z_rot;
                    iter_cnt_reg <= iter_cnt_reg + CNT_W'(1);
                end
                ST_SCALE: begin
                    o_x_reg     <= lane_out[0];
                    o_y_reg     <= lane_out[1];
                    o_valid_reg <= 1'b1;
                end
                ST_OUT: begin
                    if (i_ready) o_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = o_ready_reg;
    assign o_rom_addr = rom_addr_reg;
    assign o_valid    = o_valid_reg;
    assign o_x        = o_x_reg;
    assign o_y        = o_y_reg;

endmodule

// File: tb/tb_fft_stage_5_twiddle_rotator.sv
// Scoreboard bench for the stage-5 twiddle rotator: the stimulus process
// queues expected results, an independent monitor pops them on each output
// handshake and also checks the fixed accept-to-valid latency.
module tb_fft_stage_5_twiddle_rotator;

    localparam int DATA_W  = 16;
    localparam int ANGLE_W = 32;
    localparam int ADDR_W  = 4;
    localparam int ITER    = 16;
    localparam int LAT     = ITER + 3;

    logic                      i_clk;
    logic                      i_rst_n;
    logic                      i_valid;
    logic                      o_ready;
    logic signed [DATA_W-1:0]  i_x;
    logic signed [DATA_W-1:0]  i_y;
    logic [ADDR_W-1:0]         i_k;
    logic [ADDR_W-1:0]         o_rom_addr;
    logic signed [ANGLE_W-1:0] i_rom_data;
    logic                      o_valid;
    logic                      i_ready;
    logic signed [DATA_W-1:0]  o_x;
    logic signed [DATA_W-1:0]  o_y;

    fft_stage_5_twiddle_rotator #(
        .DATA_W  (DATA_W),
        .ANGLE_W (ANGLE_W),
        .ADDR_W  (ADDR_W),
        .ITER    (ITER)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_k        (i_k),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_x        (o_x),
        .o_y        (o_y)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // angle ROM model: round(-2*pi*k/32 * 65536), registered read
    function automatic logic signed [ANGLE_W-1:0] rom_angle(input logic [ADDR_W-1:0] a);
        int v;
        v = int'(-2.0 * 3.141592653589793 * real'(a) * 2048.0);
        return v;
    endfunction

    initial i_rom_data = '0;
    always @(posedge i_clk) i_rom_data <= rom_angle(o_rom_addr);

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int ex;
        int ey;
        int tx;
        int ty;
        bit cx;
        bit cy;
        int acc;
        int id;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_int(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // inputs change 1 time unit after the rising edge, outputs are checked there too
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int id, input int x, input int y, input int k,
                        input int ex, input int ey, input int tx, input int ty,
                        input bit cx, input bit cy, input bit push);
        int n;
        n = 0;
        tick();
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d]: o_ready=%0d after %0d cycles, want 1", id, o_ready, n);
            return;
        end
        i_valid = 1'b1;
        i_x     = DATA_W'(x);
        i_y     = DATA_W'(y);
        i_k     = ADDR_W'(k);
        tick();
        i_valid = 1'b0;
        check_int($sformatf("rom_addr[%0d]", id), int'(o_rom_addr), k, 0);
        if (push) sb_q.push_back(exp_t'{ex, ey, tx, ty, cx, cy, cyc, id});
    endtask

    task automatic wait_drain(input int id);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout[%0d]: %0d results outstanding, want 0", id, sb_q.size());
            sb_q.delete();
        end
    endtask

    // monitor: latency on each rising o_valid, data on each handshake
    initial begin : monitor
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (o_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: o_valid=1 x=%0d y=%0d, want no output", o_x, o_y);
                    end else begin
                        check_int($sformatf("latency[%0d]", sb_q[0].id), cyc - sb_q[0].acc, LAT, 0);
                    end
                end
                if (o_valid && i_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    $display("txn %0d: o_x=%0d o_y=%0d expect x=%0d y=%0d", e.id, o_x, o_y, e.ex, e.ey);
                    if (e.cx) check_int($sformatf("o_x[%0d]", e.id), int'(o_x), e.ex, e.tx);
                    if (e.cy) check_int($sformatf("o_y[%0d]", e.id), int'(o_y), e.ey, e.ty);
                end
                prev_v = o_valid;
            end
        end
    end

    initial begin : stimulus
        int hold_x;
        int hold_y;
        int n;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_x     = '0;
        i_y     = '0;
        i_k     = '0;
        repeat (3) tick();
        check_int("rst_o_valid", int'(o_valid), 0, 0);
        check_int("rst_o_x", int'(o_x), 0, 0);
        check_int("rst_o_y", int'(o_y), 0, 0);
        check_int("rst_rom_addr", int'(o_rom_addr), 0, 0);
        check_int("rst_o_ready", int'(o_ready), 0, 0);
        i_rst_n = 1'b1;
        tick();
        check_int("o_ready_after_release", int'(o_ready), 1, 0);

        // id, x, y, k, exp_x, exp_y, tol_x, tol_y, chk_x, chk_y, push
        send(1,   1000,     0,  0,  1000,     0, 1, 1, 1, 1, 1); wait_drain(1);
        send(2,  10000,     0,  4,  7071, -7071, 2, 2, 1, 1, 1); wait_drain(2);
        send(3,   1000,     0,  8,     0, -1000, 2, 2, 1, 1, 1); wait_drain(3);
        send(4,  10000,     0, 12, -7071, -7071, 2, 2, 1, 1, 1); wait_drain(4);
        send(5,      0, 10000, 15,  1951, -9808, 2, 2, 1, 1, 1); wait_drain(5);
        send(6,  32767, 32767,  4, 32767,     0, 0, 2, 1, 1, 1); wait_drain(6);
        send(7, -32768,     0,  8,     0, 32767, 0, 0, 0, 1, 1); wait_drain(7);

        // backpressure: hold off the sink for five cycles in OUT, poke i_valid meanwhile
        i_ready = 1'b0;
        send(8, 1000, 0, 8, 0, -1000, 2, 2, 1, 1, 1);
        n = 0;
        while (!o_valid && n < 60) begin
            tick();
            n++;
        end
        if (!o_valid) begin
            checks++;
            errors++;
            $display("FAIL bp_wait_valid: o_valid=0 after %0d cycles, want 1", n);
        end
        hold_x = int'(o_x);
        hold_y = int'(o_y);
        for (int c = 0; c < 5; c++) begin
            i_valid = (c % 2 == 0);
            i_x     = 16'sd12345;
            i_y     = -16'sd1;
            i_k     = 4'd3;
            tick();
            check_int($sformatf("bp_valid[%0d]", c), int'(o_valid), 1, 0);
            check_int($sformatf("bp_hold_x[%0d]", c), int'(o_x), hold_x, 0);
            check_int($sformatf("bp_hold_y[%0d]", c), int'(o_y), hold_y, 0);
            check_int($sformatf("bp_ready[%0d]", c), int'(o_ready), 0, 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain(8);

        // reset in the middle of the iterations: the sample must vanish
        send(9, 10000, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) tick();
        i_rst_n = 1'b0;
        tick();
        check_int("midrst_o_valid", int'(o_valid), 0, 0);
        check_int("midrst_o_x", int'(o_x), 0, 0);
        check_int("midrst_o_y", int'(o_y), 0, 0);
        check_int("midrst_rom_addr", int'(o_rom_addr), 0, 0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        send(10, 10000, 0, 4, 7071, -7071, 2, 2, 1, 1, 1); wait_drain(10);

        // quiet tail: any stray output is caught by the monitor
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
